mem_ctrl_pipelined: RTL and testbench
=====================================

// Module: mem_ctrl_pipelined
// PURPOSE
//  Next-gen memory controller between LSQ and data memory. Up to MAX_OUTSTANDING requests in flight.
//  Byte/half/word access with byte enables; load sign/zero extension; misaligned-access detection.
//  In-order completion tagged with ROB tag so the LSQ can match returns without serialising.
// PARAMETERS
//  ADDR_W           `D_MEMORY_ADDR_WIDTH  byte address width
//  DATA_W           `REG_VAL_WIDTH        data width, multiple of 8, >=32
//  TAG_W            `ROB_SIZE_WIDTH       ROB tag width
//  MAX_OUTSTANDING  4                     in-flight FIFO depth, power of 2, >=2
// PORTS
//  clk                 in   1            clock
//  reset               in   1            async, active-low reset
//  lsq_req_valid       in   1            LSQ request valid
//  lsq_req_op          in   memory_op_t  LOAD / STORE
//  lsq_req_size        in   mem_size_t   BYTE / HALF / WORD
//  lsq_req_unsigned    in   1            1: zero-extend load, 0: sign-extend
//  lsq_req_address     in   ADDR_W       byte address
//  lsq_req_data        in   DATA_W       store data, LSB-aligned
//  lsq_req_tag         in   TAG_W        ROB tag
//  mem_ctrl_ready      out  1            controller accepts request this cycle
//  mem_ctrl_done       out  1            one-cycle completion pulse
//  mem_ctrl_data       out  DATA_W       extended load data; 0 for stores/errors
//  mem_ctrl_tag        out  TAG_W        tag of completing request
//  mem_ctrl_err        out  1            completion is misaligned fault
//  memory_ready        in   1            memory accepts request
//  memory_ack          in   1            memory completes oldest request (in order)
//  memory_data_return  in   DATA_W       full-word read data, valid with memory_ack
//  memory_req_valid    out  1            request to memory
//  memory_req_op       out  memory_op_t  LOAD / STORE
//  memory_req_address  out  ADDR_W       word-aligned address (low bits cleared)
//  memory_req_data     out  DATA_W       store data shifted into byte lanes
//  memory_req_be       out  DATA_W/8     byte enables (all 1s on load)
// BEHAVIOUR
//  Reset (reset==0, async): all outputs 0, FIFO empty, issue stage empty; mem_ctrl_ready 0 during reset, 1 first cycle after.
//  Accept: lsq_req_valid && mem_ctrl_ready. Misaligned = HALF with addr[0]!=0, or WORD with addr[1:0]!=0.
//  Issue stage (1 reg): aligned request latched next cycle; memory_req_* driven from it, held stable until memory_ready.
//  memory_req_valid && memory_ready -> request sent; entry {tag,op,size,unsigned,offset,err=0} pushed to in-flight FIFO.
//  Misaligned request skips memory: pushed to FIFO directly with err=1, same cycle as accept+1; ordering preserved.
//  mem_ctrl_ready = issue stage free-or-draining this cycle && (fifo_count + issue_occupied) < MAX_OUTSTANDING.
//  Completion (registered, 1 cycle after event): head entry err=1 -> done,err=1,data=0 when at head, no ack needed.
//    head entry err=0 -> waits for memory_ack; load data = memory_data_return >> (8*offset), masked to size, extended.
//    store -> done with data=0. mem_ctrl_tag = head tag. Max one completion per cycle; pop on completion.
//  Latency: aligned load with memory_ready=1 and ack next cycle -> done 3 cycles after accept.
//  Simultaneous push and pop: count unchanged; full FIFO with pop same cycle still blocks accept (no bypass).
//  memory_ack with no memory-bound head entry: ignored, no done, no state change (verification assertion flags it).
//  Pointers wrap modulo MAX_OUTSTANDING; count is $clog2(MAX_OUTSTANDING)+1 bits.
//  Reset mid-operation: in-flight entries discarded; late memory_ack after reset ignored per rule above.
// STRUCTURE
//  Package mem_ctrl_pkg: mem_size_t enum, inflight_entry_t struct, funcs calc_be(), align_store(), extend_load().
//  memory_op_t reused from the existing shared package.
//  Sub-module: inflight_fifo (parametrised sync FIFO: push/pop/full/empty/count, async active-low reset).
// TESTING
//  LW addr 0x10 tag 3, ready=1, ack next cycle data 0xDEADBEEF -> done, tag 3, data 0xDEADBEEF, err 0, 3 cycles after accept.
//  LB signed addr 0x13, return 0x80FF_FF00 -> data 0xFFFFFF80; LBU same -> 0x00000080.
//  SH addr 0x22 data 0x1234 -> memory_req_address 0x20, be 4'b1100, memory_req_data 0x1234_0000; done data 0.
//  LW addr 0x11 tag 5 -> memory_req_valid never asserts, done err=1 tag 5 data 0.
//  5 back-to-back LWs, memory_ack held 0 -> ready drops after 4th in flight; acks return in tag order, ready re-rises.
//  memory_ready held 0 with issue stage full -> memory_req_* stable; assert reset mid-flight -> outputs 0, ready 1 after release.

Source files
------------

// File: rtl/mem_ctrl_pipelined_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
//   Shared types and helpers for the pipelined memory controller.
//   - memory_op_t      : LOAD / STORE encoding (same encoding the LSQ uses)
//   - mem_size_t       : BYTE / HALF / WORD access size
//   - inflight_entry_t : bookkeeping kept per request until it completes
//   - is_misaligned()  : alignment check on the low address bits
//   - calc_be()        : byte enables for a request
//   - align_store()    : moves LSB-aligned store data into its byte lanes
//   - extend_load()    : picks the addressed bytes from a returned word and
//                        sign/zero extends them
//   Helpers work on MAX_DATA_W-wide values so any DATA_W up to 64 can use
//   them by zero-extending inputs and truncating results.
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } memory_op_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_t;

  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;
  localparam int unsigned MAX_TAG_W  = 16;
  localparam int unsigned OFFSET_W   = 3;   // byte offset inside a 64-bit word

  typedef struct packed {
    logic [MAX_TAG_W-1:0] tag;
    memory_op_t           op;
    mem_size_t            size;
    logic                 is_unsigned;
    logic [OFFSET_W-1:0]  offset;
    logic                 err;          // misaligned: completes without memory
  } inflight_entry_t;

  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
    return ((size == SIZE_HALF) && addr_lo[0]) ||
           ((size == SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

  function automatic logic [MAX_BE_W-1:0] calc_be(input memory_op_t op, input mem_size_t size,
                                                  input logic [OFFSET_W-1:0] offset);
    logic [MAX_BE_W-1:0] base;
    // Loads always fetch the whole word; extraction happens on return.
    if (op == MEM_LOAD) return '1;
    // NOTE: every path through combinational code assigns the result (default
    // arm included); a missing assignment would infer a latch in always_comb.
    case (size)
      SIZE_BYTE: base = MAX_BE_W'(8'h01);
      SIZE_HALF: base = MAX_BE_W'(8'h03);
      default:   base = MAX_BE_W'(8'h0F);
    endcase
    return base << offset;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] align_store(input logic [MAX_DATA_W-1:0] data,
                                                        input logic [OFFSET_W-1:0] offset);
    return data << {offset, 3'b000};
  endfunction

  function automatic logic [MAX_DATA_W-1:0] extend_load(input logic [MAX_DATA_W-1:0] raw,
                                                        input mem_size_t size,
                                                        input logic is_unsigned,
                                                        input logic [OFFSET_W-1:0] offset);
    logic [MAX_DATA_W-1:0] lane;
    logic                  fill;
    lane = raw >> {offset, 3'b000};
    case (size)
      SIZE_BYTE: begin
        fill = !is_unsigned && lane[7];
        return {{(MAX_DATA_W-8){fill}}, lane[7:0]};
      end
      SIZE_HALF: begin
        fill = !is_unsigned && lane[15];
        return {{(MAX_DATA_W-16){fill}}, lane[15:0]};
      end
      default: begin
        fill = !is_unsigned && lane[31];
        return {{(MAX_DATA_W-32){fill}}, lane[31:0]};
      end
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_pipelined_if.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pipelined_if
//   Bundles the LSQ-side and memory-side buses of the controller.
//   modport slave  : controller view (takes LSQ requests and memory replies,
//                    drives completions and memory requests)
//   modport master : environment view (LSQ + memory model), the mirror image
//   LSQ side    : lsq_req_{valid,op,size,unsigned,address,data,tag} ->
//                 mem_ctrl_{ready,done,data,tag,err} <-
//   Memory side : memory_req_{valid,op,address,data,be} ->
//                 memory_{ready,ack,data_return} <-
// ---------------------------------------------------------------------------
interface mem_ctrl_pipelined_if
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);
  // LSQ request / completion
  logic              lsq_req_valid;
  memory_op_t        lsq_req_op;
  mem_size_t         lsq_req_size;
  logic              lsq_req_unsigned;
  logic [ADDR_W-1:0] lsq_req_address;
  logic [DATA_W-1:0] lsq_req_data;
  logic [TAG_W-1:0]  lsq_req_tag;
  logic              mem_ctrl_ready;
  logic              mem_ctrl_done;
  logic [DATA_W-1:0] mem_ctrl_data;
  logic [TAG_W-1:0]  mem_ctrl_tag;
  logic              mem_ctrl_err;

  // Data memory
  logic                memory_ready;
  logic                memory_ack;
  logic [DATA_W-1:0]   memory_data_return;
  logic                memory_req_valid;
  memory_op_t          memory_req_op;
  logic [ADDR_W-1:0]   memory_req_address;
  logic [DATA_W-1:0]   memory_req_data;
  logic [DATA_W/8-1:0] memory_req_be;

  modport slave (
    input  lsq_req_valid, lsq_req_op, lsq_req_size, lsq_req_unsigned,
           lsq_req_address, lsq_req_data, lsq_req_tag,
           memory_ready, memory_ack, memory_data_return,
    output mem_ctrl_ready, mem_ctrl_done, mem_ctrl_data, mem_ctrl_tag, mem_ctrl_err,
           memory_req_valid, memory_req_op, memory_req_address, memory_req_data,
           memory_req_be
  );

  modport master (
    output lsq_req_valid, lsq_req_op, lsq_req_size, lsq_req_unsigned,
           lsq_req_address, lsq_req_data, lsq_req_tag,
           memory_ready, memory_ack, memory_data_return,
    input  mem_ctrl_ready, mem_ctrl_done, mem_ctrl_data, mem_ctrl_tag, mem_ctrl_err,
           memory_req_valid, memory_req_op, memory_req_address, memory_req_data,
           memory_req_be
  );
endinterface

// File: rtl/mem_ctrl_pipelined_inflight_fifo.sv
// ---------------------------------------------------------------------------
// inflight_fifo
//   Synchronous FIFO holding requests between issue and completion.
//   Ports:
//     clk, reset        clock, asynchronous active-low reset
//     i_push, i_wdata   write one entry
//     i_pop             drop the head entry
//     o_rdata           head entry (valid when !o_empty)
//     o_full, o_empty   status
//     o_count           number of stored entries ($clog2(DEPTH)+1 bits)
//   DEPTH must be a power of two so the pointers wrap naturally.
//   Push on full and pop on empty are ignored.
// ---------------------------------------------------------------------------
module inflight_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // NOTE: the storage array has no reset; the count/pointers decide what is
  // valid, and leaving RAM unreset lets it map onto plain flops or memory.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/mem_ctrl_pipelined.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pipelined
//   Pipelined memory controller between the LSQ and data memory.
//   Ports:
//     clk    clock
//     reset  asynchronous active-low reset
//     bus    mem_ctrl_pipelined_if.slave (LSQ request/completion + memory bus)
//   Flow: accepted request -> one-entry issue register driving memory_req_*
//   -> in-flight FIFO once sent -> registered completion pulse in order.
//   Misaligned requests also pass through the issue register (keeping order
//   with older aligned requests) but never raise memory_req_valid; they move
//   to the FIFO on the next edge and complete as soon as they reach the head.
// ---------------------------------------------------------------------------
module mem_ctrl_pipelined
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int TAG_W           = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_ctrl_pipelined_if.slave  bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CNT_W:0] MAX_OCC = (CNT_W + 1)'(MAX_OUTSTANDING);

  // Issue stage
  logic                r_iss_valid;
  logic                r_iss_err;
  memory_op_t          r_iss_op;
  mem_size_t           r_iss_size;
  logic                r_iss_unsigned;
  logic [OFFSET_W-1:0] r_iss_off;
  logic [TAG_W-1:0]    r_iss_tag;
  logic [ADDR_W-1:0]   r_iss_addr;
  logic [DATA_W-1:0]   r_iss_data;
  logic [BE_W-1:0]     r_iss_be;

  // Completion stage
  logic                r_done;
  logic [DATA_W-1:0]   r_data;
  logic [TAG_W-1:0]    r_tag;
  logic                r_err;

  logic                w_ready;
  logic                w_accept;
  logic                w_misaligned;
  logic [OFFSET_W-1:0] w_req_off;
  logic                w_iss_drain;
  logic                w_complete;
  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_count;
  logic [CNT_W:0]      w_occupancy;
  inflight_entry_t     w_push_entry;
  inflight_entry_t     w_head;

  assign w_req_off    = OFFSET_W'(bus.lsq_req_address[OFF_W-1:0]);
  assign w_misaligned = is_misaligned(bus.lsq_req_size, bus.lsq_req_address[1:0]);

  // The issue entry leaves this cycle if memory takes it, or unconditionally
  // for a misaligned entry that never goes to memory.
  assign w_iss_drain = r_iss_valid && (r_iss_err || bus.memory_ready);

  // Occupancy counts the issue entry too, so FIFO space is reserved before a
  // request is sent. A pop in the same cycle does not free a slot early.
  assign w_occupancy = {1'b0, w_count} + {{CNT_W{1'b0}}, r_iss_valid};
  assign w_ready     = reset && (!r_iss_valid || w_iss_drain) &&
                       (w_occupancy < MAX_OCC) && !w_full;
  assign w_accept    = bus.lsq_req_valid && w_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_iss_valid    <= 1'b0;
      r_iss_err      <= 1'b0;
      r_iss_op       <= MEM_LOAD;
      r_iss_size     <= SIZE_BYTE;
      r_iss_unsigned <= 1'b0;
      r_iss_off      <= '0;
      r_iss_tag      <= '0;
      r_iss_addr     <= '0;
      r_iss_data     <= '0;
      r_iss_be       <= '0;
    end else if (w_accept) begin
      r_iss_valid    <= 1'b1;
      r_iss_err      <= w_misaligned;
      r_iss_op       <= bus.lsq_req_op;
      r_iss_size     <= bus.lsq_req_size;
      r_iss_unsigned <= bus.lsq_req_unsigned;
      r_iss_off      <= w_req_off;
      r_iss_tag      <= bus.lsq_req_tag;
      r_iss_addr     <= {bus.lsq_req_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      r_iss_data     <= DATA_W'(align_store(MAX_DATA_W'(bus.lsq_req_data), w_req_off));
      r_iss_be       <= BE_W'(calc_be(bus.lsq_req_op, bus.lsq_req_size, w_req_off));
    end else if (w_iss_drain) begin
      r_iss_valid    <= 1'b0;
    end
  end

  assign bus.memory_req_valid   = r_iss_valid && !r_iss_err;
  assign bus.memory_req_op      = r_iss_op;
  assign bus.memory_req_address = r_iss_addr;
  assign bus.memory_req_data    = r_iss_data;
  assign bus.memory_req_be      = r_iss_be;

  always_comb begin
    w_push_entry = '{tag:         MAX_TAG_W'(r_iss_tag),
                     op:          r_iss_op,
                     size:        r_iss_size,
                     is_unsigned: r_iss_unsigned,
                     offset:      r_iss_off,
                     err:         r_iss_err};
  end

  inflight_fifo #(
    .WIDTH ($bits(inflight_entry_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) u_inflight_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_iss_drain),
    .i_wdata (w_push_entry),
    .i_pop   (w_complete),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // An error entry completes on its own; a memory-bound entry needs the ack.
  // An ack with nothing memory-bound at the head is dropped.
  assign w_complete = !w_empty && (w_head.err || bus.memory_ack);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done <= 1'b0;
      r_data <= '0;
      r_tag  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_complete;
      if (w_complete) begin
        r_tag <= TAG_W'(w_head.tag);
        r_err <= w_head.err;
        if (w_head.err || (w_head.op == MEM_STORE)) r_data <= '0;
        else r_data <= DATA_W'(extend_load(MAX_DATA_W'(bus.memory_data_return),
                                           w_head.size, w_head.is_unsigned, w_head.offset));
      end else begin
        r_tag  <= '0;
        r_err  <= 1'b0;
        r_data <= '0;
      end
    end
  end

  assign bus.mem_ctrl_ready = w_ready;
  assign bus.mem_ctrl_done  = r_done;
  assign bus.mem_ctrl_data  = r_data;
  assign bus.mem_ctrl_tag   = r_tag;
  assign bus.mem_ctrl_err   = r_err;
endmodule

// File: tb/tb_mem_ctrl_pipelined.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl_pipelined
//   Directed bench for mem_ctrl_pipelined. Inputs change 1 ns after the
//   rising edge; outputs are compared later in the same cycle.
// ---------------------------------------------------------------------------
module tb_mem_ctrl_pipelined;
  import mem_ctrl_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 5;
  localparam int MAX_OS = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_ctrl_pipelined_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  mem_ctrl_pipelined #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .MAX_OUTSTANDING(MAX_OS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input memory_op_t op, input mem_size_t size, input logic uns,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                           input logic [TAG_W-1:0] tag);
    bus.lsq_req_valid    = 1'b1;
    bus.lsq_req_op       = op;
    bus.lsq_req_size     = size;
    bus.lsq_req_unsigned = uns;
    bus.lsq_req_address  = addr;
    bus.lsq_req_data     = data;
    bus.lsq_req_tag      = tag;
  endtask

  // Present a request, confirm it is accepted, advance to the cycle after.
  task automatic send(input memory_op_t op, input mem_size_t size, input logic uns,
                      input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                      input logic [TAG_W-1:0] tag);
    drive_req(op, size, uns, addr, data, tag);
    #1;
    check("accept_ready", bus.mem_ctrl_ready, 1);
    step();
    bus.lsq_req_valid = 1'b0;
  endtask

  task automatic check_done(input string name, input logic [TAG_W-1:0] tag,
                            input logic [DATA_W-1:0] data, input logic err);
    check({name, "_done"}, bus.mem_ctrl_done, 1);
    check({name, "_tag"},  bus.mem_ctrl_tag, tag);
    check({name, "_data"}, bus.mem_ctrl_data, data);
    check({name, "_err"},  bus.mem_ctrl_err, err);
  endtask

  task automatic ack_cycle(input logic [DATA_W-1:0] ret);
    bus.memory_ack         = 1'b1;
    bus.memory_data_return = ret;
    step();
    bus.memory_ack         = 1'b0;
  endtask

  initial begin
    bus.lsq_req_valid      = 1'b0;
    bus.lsq_req_op         = MEM_LOAD;
    bus.lsq_req_size       = SIZE_WORD;
    bus.lsq_req_unsigned   = 1'b0;
    bus.lsq_req_address    = '0;
    bus.lsq_req_data       = '0;
    bus.lsq_req_tag        = '0;
    bus.memory_ready       = 1'b0;
    bus.memory_ack         = 1'b0;
    bus.memory_data_return = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", bus.mem_ctrl_ready, 0);
    check("rst_done", bus.mem_ctrl_done, 0);
    check("rst_mreq_valid", bus.memory_req_valid, 0);
    check("rst_data", bus.mem_ctrl_data, 0);
    reset = 1'b1;
    #1;
    check("ready_after_rst", bus.mem_ctrl_ready, 1);
    bus.memory_ready = 1'b1;

    // LW 0x10 tag 3: done three cycles after accept
    send(MEM_LOAD, SIZE_WORD, 1'b0, 32'h10, '0, 5'd3);
    check("lw_mreq_valid", bus.memory_req_valid, 1);
    check("lw_mreq_addr", bus.memory_req_address, 32'h10);
    check("lw_mreq_be", bus.memory_req_be, 4'hF);
    check("lw_mreq_op", bus.memory_req_op, MEM_LOAD);
    check("lw_done_c1", bus.mem_ctrl_done, 0);
    step();
    check("lw_done_c2", bus.mem_ctrl_done, 0);
    ack_cycle(32'hDEAD_BEEF);
    check_done("lw", 5'd3, 32'hDEAD_BEEF, 1'b0);
    step();
    check("lw_done_pulse", bus.mem_ctrl_done, 0);

    // LB signed from byte 3
    send(MEM_LOAD, SIZE_BYTE, 1'b0, 32'h13, '0, 5'd6);
    check("lb_mreq_addr", bus.memory_req_address, 32'h10);
    check("lb_mreq_be", bus.memory_req_be, 4'hF);
    step();
    ack_cycle(32'h80FF_FF00);
    check_done("lb", 5'd6, 32'hFFFF_FF80, 1'b0);

    // LBU same address and data
    send(MEM_LOAD, SIZE_BYTE, 1'b1, 32'h13, '0, 5'd7);
    step();
    ack_cycle(32'h80FF_FF00);
    check_done("lbu", 5'd7, 32'h0000_0080, 1'b0);

    // SH 0x22: upper half lanes
    send(MEM_STORE, SIZE_HALF, 1'b0, 32'h22, 32'h0000_1234, 5'd9);
    check("sh_mreq_op", bus.memory_req_op, MEM_STORE);
    check("sh_mreq_addr", bus.memory_req_address, 32'h20);
    check("sh_mreq_be", bus.memory_req_be, 4'b1100);
    check("sh_mreq_data", bus.memory_req_data, 32'h1234_0000);
    step();
    ack_cycle(32'hFFFF_FFFF);
    check_done("sh", 5'd9, 32'h0, 1'b0);

    // Misaligned LW 0x11 tag 5: never reaches memory
    send(MEM_LOAD, SIZE_WORD, 1'b0, 32'h11, '0, 5'd5);
    check("mis_mreq_valid_c1", bus.memory_req_valid, 0);
    step();
    check("mis_mreq_valid_c2", bus.memory_req_valid, 0);
    check("mis_done_c2", bus.mem_ctrl_done, 0);
    step();
    check_done("mis", 5'd5, 32'h0, 1'b1);

    // Five back-to-back LWs with no acks: fifth is held off
    for (int i = 0; i < 5; i++) begin
      drive_req(MEM_LOAD, SIZE_WORD, 1'b0, 32'h40 + 32'(4 * i), '0, TAG_W'(8 + i));
      #1;
      check("b2b_ready", bus.mem_ctrl_ready, (i < 4) ? 1 : 0);
      if (i < 4) step();
    end
    step();
    check("full_blocks", bus.mem_ctrl_ready, 0);
    for (int k = 0; k < 5; k++) begin
      bus.memory_ack         = 1'b1;
      bus.memory_data_return = DATA_W'(32'h1000 + 8 + k);
      if (k == 1) begin
        #1;
        check("ready_rerise", bus.mem_ctrl_ready, 1);
      end
      step();
      if (k == 1) bus.lsq_req_valid = 1'b0;
      check_done("b2b", TAG_W'(8 + k), DATA_W'(32'h1000 + 8 + k), 1'b0);
    end
    bus.memory_ack = 1'b0;
    step();
    check("b2b_idle", bus.mem_ctrl_done, 0);

    // Memory stalled: request held stable, then reset mid-flight
    bus.memory_ready = 1'b0;
    send(MEM_LOAD, SIZE_WORD, 1'b0, 32'h80, '0, 5'd20);
    check("stall_ready", bus.mem_ctrl_ready, 0);
    for (int s = 0; s < 3; s++) begin
      check("stall_mreq_valid", bus.memory_req_valid, 1);
      check("stall_mreq_addr", bus.memory_req_address, 32'h80);
      step();
    end
    #2;
    reset = 1'b0;
    #1;
    check("midrst_mreq_valid", bus.memory_req_valid, 0);
    check("midrst_ready", bus.mem_ctrl_ready, 0);
    check("midrst_done", bus.mem_ctrl_done, 0);
    step();
    reset = 1'b1;
    #1;
    check("postrst_ready", bus.mem_ctrl_ready, 1);
    check("postrst_mreq_valid", bus.memory_req_valid, 0);
    bus.memory_ready = 1'b1;
    ack_cycle(32'h5555_5555);
    check("late_ack_ignored", bus.mem_ctrl_done, 0);

    // Fresh load after reset completes with its own data
    send(MEM_LOAD, SIZE_HALF, 1'b1, 32'h32, '0, 5'd1);
    step();
    ack_cycle(32'hBEEF_0BAD);
    check_done("postrst_lhu", 5'd1, 32'h0000_BEEF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
